// File: rtl/data_sram_bridge_pkg.sv
// Shared types for the memory-stage data request and the SRAM-like bridge FSM.
// Request structs match the layout the memory stage drives.
package data_sram_bridge_pkg;

    typedef enum logic [1:0] {
        MSIZE_B = 2'b00,
        MSIZE_H = 2'b01,
        MSIZE_W = 2'b10
    } msize_t;

    typedef struct packed {
        logic        ren;
        logic [31:0] addr;
        msize_t      size;
    } m_r_t;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wd;
        msize_t      size;
    } m_w_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        DONE = 2'b11
    } bridge_state_t;

endpackage

// File: rtl/data_sram_bridge.sv
// Turns one memory-stage request into a single SRAM-like data-bus transaction,
// stalling the pipeline until it completes and holding the read word until M->W.
module data_sram_bridge
    import data_sram_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  m_r_t        mread,
    input  m_w_t        mwrite,
    output logic [31:0] rd,
    output logic        dstall,
    input  logic        m_advance,
    input  logic        flushM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    bridge_state_t state;
    logic          discard;
    logic [31:0]   rd_q;

    logic          wr_q;
    logic [1:0]    size_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;

    logic          pending;
    logic          issue;
    logic          req_wr;
    logic [1:0]    req_size;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;

    // Writes win over reads when the memory stage raises both.
    always_comb begin
        pending   = mread.ren | mwrite.wen;
        issue     = (state == IDLE) & pending & ~flushM;
        req_wr    = mwrite.wen;
        req_size  = mwrite.wen ? mwrite.size : mread.size;
        req_addr  = mwrite.wen ? mwrite.addr : mread.addr;
        req_wdata = mwrite.wen ? mwrite.wd   : 32'd0;
    end

    // Bus fields are forced to zero whenever no request is being presented.
    always_comb begin
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'b00;
        data_addr  = 32'd0;
        data_wdata = 32'd0;
        case (state)
            IDLE: begin
                if (issue) begin
                    data_req   = 1'b1;
                    data_wr    = req_wr;
                    data_size  = req_size;
                    data_addr  = req_addr;
                    data_wdata = req_wdata;
                end
            end
            ADDR: begin
                data_req   = 1'b1;
                data_wr    = wr_q;
                data_size  = size_q;
                data_addr  = addr_q;
                data_wdata = wdata_q;
            end
            default: ;
        endcase
    end

    assign dstall = ((state == IDLE) & pending) | (state == ADDR) | (state == DATA);
    assign rd     = rd_q;

    // Request latch: captured on every issue so ADDR can replay it and DATA knows wr.
    always_ff @(posedge clk) begin
        if (issue) begin
            wr_q    <= req_wr;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            discard <= 1'b0;
            rd_q    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    discard <= 1'b0;
                    if (issue) begin
                        state <= data_addr_ok ? DATA : ADDR;
                    end
                end
                ADDR: begin
                    if (flushM) begin
                        discard <= 1'b1;
                    end
                    if (data_addr_ok) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (flushM) begin
                        discard <= 1'b1;
                    end
                    // A killed access still drains its data phase; only the result is dropped.
                    if (data_data_ok) begin
                        if (discard | flushM) begin
                            state   <= IDLE;
                            discard <= 1'b0;
                        end else begin
                            state <= DONE;
                            if (!wr_q) begin
                                rd_q <= data_rdata;
                            end
                        end
                    end
                end
                DONE: begin
                    if (m_advance | flushM) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Scoreboard bench for data_sram_bridge: a bus responder checks every address
// handshake and a monitor checks rd whenever a read access completes.
module tb_data_sram_bridge;
    import data_sram_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    m_r_t        mread;
    m_w_t        mwrite;
    logic [31:0] rd;
    logic        dstall;
    logic        m_advance;
    logic        flushM;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    data_sram_bridge dut (
        .clk          (clk),
        .reset        (reset),
        .mread        (mread),
        .mwrite       (mwrite),
        .rd           (rd),
        .dstall       (dstall),
        .m_advance    (m_advance),
        .flushM       (flushM),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    logic [31:0] rd_exp_q[$];

    int vectors    = 0;
    int miscompares = 0;
    int txn_count  = 0;

    int          addr_wait = 0;
    int          data_wait = 0;
    logic [31:0] rdata_val = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus responder: decides addr_ok/data_ok each cycle, 2 time units after the edge.
    initial begin : bus_model
        int  bstate;
        int  acnt;
        int  dcnt;
        logic ao_prev;
        logic do_prev;
        bus_exp_t e;
        bstate = 0; acnt = 0; dcnt = 0; ao_prev = 1'b0; do_prev = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                bstate = 0; acnt = 0; dcnt = 0; ao_prev = 1'b0; do_prev = 1'b0;
                data_addr_ok = 1'b0;
                data_data_ok = 1'b0;
            end else begin
                if (ao_prev) begin
                    bstate = 1;
                    dcnt   = 0;
                    acnt   = 0;
                end
                if (do_prev) begin
                    bstate = 0;
                end
                data_addr_ok = 1'b0;
                data_data_ok = 1'b0;
                if (bstate == 0) begin
                    if (data_req) begin
                        if (acnt >= addr_wait) data_addr_ok = 1'b1;
                        else acnt++;
                    end
                end else begin
                    if (dcnt >= data_wait) begin
                        data_data_ok = 1'b1;
                        data_rdata   = rdata_val;
                    end else begin
                        dcnt++;
                    end
                end
                ao_prev = data_addr_ok & data_req;
                do_prev = data_data_ok;
                if (ao_prev) begin
                    txn_count++;
                    if (bus_q.size() == 0) begin
                        miscompares++;
                        vectors++;
                        $display("FAIL unexpected_txn: got addr %h expected no transaction", data_addr);
                    end else begin
                        e = bus_q.pop_front();
                        chk("bus_wr",    {31'd0, data_wr},   {31'd0, e.wr});
                        chk("bus_size",  {30'd0, data_size}, {30'd0, e.size});
                        chk("bus_addr",  data_addr,  e.addr);
                        chk("bus_wdata", data_wdata, e.wdata);
                    end
                end
            end
        end
    end

    // Result monitor: a read result is presented when dstall falls with the read still up.
    initial begin : rd_monitor
        logic prev_dstall;
        logic [31:0] exp_v;
        prev_dstall = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && prev_dstall && !dstall && mread.ren && !mwrite.wen) begin
                if (rd_exp_q.size() == 0) begin
                    miscompares++;
                    vectors++;
                    $display("FAIL unexpected_result: got rd %h expected no result", rd);
                end else begin
                    exp_v = rd_exp_q.pop_front();
                    chk("rd_result", rd, exp_v);
                end
            end
            prev_dstall = dstall;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish within 200000");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Counts stall cycles starting from the cycle in which the request was presented.
    task automatic wait_done(output int n);
        n = 0;
        @(negedge clk);
        while (dstall && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            miscompares++;
            vectors++;
            $display("FAIL done_timeout: got dstall still high expected release within 50 cycles");
        end
    endtask

    task automatic advance();
        m_advance = 1'b1;
        cyc();
        m_advance = 1'b0;
        mread     = '0;
        mwrite    = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'd0, data_req},   32'd0);
        chk({tag, "_wr"},    {31'd0, data_wr},    32'd0);
        chk({tag, "_size"},  {30'd0, data_size},  32'd0);
        chk({tag, "_addr"},  data_addr,           32'd0);
        chk({tag, "_wdata"}, data_wdata,          32'd0);
        chk({tag, "_dstall"},{31'd0, dstall},     32'd0);
        chk({tag, "_rd"},    rd,                  32'd0);
    endtask

    initial begin : stimulus
        int n;
        int txn_before;
        reset     = 1'b1;
        mread     = '0;
        mwrite    = '0;
        m_advance = 1'b0;
        flushM    = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs("por");

        // Word read, minimum latency.
        cyc();
        addr_wait = 0; data_wait = 0; rdata_val = 32'hDEAD_BEEF;
        bus_q.push_back('{1'b0, 2'b10, 32'h8000_0010, 32'd0});
        rd_exp_q.push_back(32'hDEAD_BEEF);
        mread = '{1'b1, 32'h8000_0010, MSIZE_W};
        wait_done(n);
        chk("rd_word_stalls", n, 2);
        chk("rd_word_done_rd", rd, 32'hDEAD_BEEF);
        advance();
        @(negedge clk);
        chk("rd_word_idle_dstall", {31'd0, dstall}, 32'd0);
        chk("rd_word_idle_req", {31'd0, data_req}, 32'd0);

        // Byte write with addr_ok delayed 3 cycles.
        cyc();
        addr_wait = 3; data_wait = 0;
        bus_q.push_back('{1'b1, 2'b00, 32'h8000_0003, 32'h0000_00AB});
        mwrite = '{1'b1, 32'h8000_0003, 32'h0000_00AB, MSIZE_B};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wrb_req_held",   {31'd0, data_req},  32'd1);
            chk("wrb_wr_held",    {31'd0, data_wr},   32'd1);
            chk("wrb_size_held",  {30'd0, data_size}, 32'd0);
            chk("wrb_addr_held",  data_addr,          32'h8000_0003);
            chk("wrb_wdata_held", data_wdata,         32'h0000_00AB);
            chk("wrb_dstall",     {31'd0, dstall},    32'd1);
            cyc();
        end
        @(negedge clk);
        chk("wrb_data_dstall", {31'd0, dstall},   32'd1);
        chk("wrb_data_req",    {31'd0, data_req}, 32'd0);
        @(negedge clk);
        chk("wrb_done_dstall", {31'd0, dstall},   32'd0);
        chk("wrb_rd_kept",     rd,                32'hDEAD_BEEF);
        advance();

        // Read completes while the pipeline is held for 5 cycles.
        addr_wait = 0; data_wait = 1; rdata_val = 32'hCAFE_F00D;
        txn_before = txn_count;
        bus_q.push_back('{1'b0, 2'b10, 32'h8000_0014, 32'd0});
        rd_exp_q.push_back(32'hCAFE_F00D);
        mread = '{1'b1, 32'h8000_0014, MSIZE_W};
        wait_done(n);
        chk("hold_stalls", n, 3);
        for (int i = 0; i < 5; i++) begin
            chk("hold_rd",     rd,                 32'hCAFE_F00D);
            chk("hold_req",    {31'd0, data_req},  32'd0);
            chk("hold_dstall", {31'd0, dstall},    32'd0);
            @(negedge clk);
        end
        chk("hold_txn_count", txn_count - txn_before, 1);
        advance();

        // flushM while the address phase is pending.
        addr_wait = 2; data_wait = 1; rdata_val = 32'h1234_5678;
        bus_q.push_back('{1'b0, 2'b10, 32'h8000_0020, 32'd0});
        mread = '{1'b1, 32'h8000_0020, MSIZE_W};
        @(negedge clk);
        chk("fl_c0_req", {31'd0, data_req}, 32'd1);
        cyc();
        flushM = 1'b1;
        @(negedge clk);
        chk("fl_c1_req",  {31'd0, data_req}, 32'd1);
        chk("fl_c1_addr", data_addr,          32'h8000_0020);
        cyc();
        flushM = 1'b0;
        mread  = '0;
        @(negedge clk);
        chk("fl_c2_req",  {31'd0, data_req}, 32'd1);
        chk("fl_c2_addr", data_addr,          32'h8000_0020);
        cyc();
        bus_q.push_back('{1'b0, 2'b10, 32'h8000_0040, 32'd0});
        rd_exp_q.push_back(32'h0BAD_F00D);
        mread = '{1'b1, 32'h8000_0040, MSIZE_W};
        @(negedge clk);
        chk("fl_c3_req",    {31'd0, data_req}, 32'd0);
        chk("fl_c3_dstall", {31'd0, dstall},   32'd1);
        cyc();
        @(negedge clk);
        chk("fl_c4_req",    {31'd0, data_req}, 32'd0);
        chk("fl_c4_dstall", {31'd0, dstall},   32'd1);
        cyc();
        addr_wait = 0; data_wait = 0; rdata_val = 32'h0BAD_F00D;
        @(negedge clk);
        chk("fl_rd_kept",  rd,                 32'hCAFE_F00D);
        chk("fl_reissue",  {31'd0, data_req},  32'd1);
        wait_done(n);
        chk("fl_next_stalls", n, 1);
        advance();

        // Reset while the data phase is outstanding.
        addr_wait = 0; data_wait = 3; rdata_val = 32'h7777_7777;
        bus_q.push_back('{1'b0, 2'b10, 32'h8000_0080, 32'd0});
        mread = '{1'b1, 32'h8000_0080, MSIZE_W};
        @(negedge clk);
        chk("rst_c0_dstall", {31'd0, dstall}, 32'd1);
        cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_c1_dstall", {31'd0, dstall}, 32'd1);
        cyc();
        reset = 1'b0;
        mread = '0;
        @(negedge clk);
        chk_reset_outputs("rst_mid");
        cyc();
        data_wait = 0; rdata_val = 32'h55AA_55AA;
        bus_q.push_back('{1'b0, 2'b10, 32'h8000_0090, 32'd0});
        rd_exp_q.push_back(32'h55AA_55AA);
        mread = '{1'b1, 32'h8000_0090, MSIZE_W};
        wait_done(n);
        chk("rst_fresh_stalls", n, 2);
        advance();

        // Simultaneous read and write: the write goes out and rd is untouched.
        bus_q.push_back('{1'b1, 2'b01, 32'h8000_0100, 32'h1122_3344});
        mread  = '{1'b1, 32'h8000_0200, MSIZE_W};
        mwrite = '{1'b1, 32'h8000_0100, 32'h1122_3344, MSIZE_H};
        wait_done(n);
        chk("prio_stalls", n, 2);
        chk("prio_rd_kept", rd, 32'h55AA_55AA);
        advance();

        // flushM in IDLE suppresses the request for that cycle.
        txn_before = txn_count;
        mread  = '{1'b1, 32'h8000_0300, MSIZE_W};
        flushM = 1'b1;
        @(negedge clk);
        chk("idle_flush_req", {31'd0, data_req}, 32'd0);
        cyc();
        flushM = 1'b0;
        mread  = '0;
        @(negedge clk);
        chk("idle_flush_dstall", {31'd0, dstall}, 32'd0);
        chk("idle_flush_txn", txn_count - txn_before, 0);

        repeat (2) cyc();
        chk("bus_q_empty", bus_q.size(), 0);
        chk("rd_q_empty",  rd_exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
